// File: rtl/hazard_ctrl_mdu.sv
// Hazard control for the 5-stage MIPS pipeline: load-use, branch/JR operand and MDU scoreboard stalls.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_mdu #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [5:0]        IF_ID_OP,
    input  logic [5:0]        IF_ID_Funct,
    input  logic [REG_AW-1:0] IF_ID_RS,
    input  logic [REG_AW-1:0] IF_ID_RT,
    input  logic              IF_ID_invalidRt,
    input  logic              ID_EX_MemtoReg,
    input  logic              ID_EX_RegWrite,
    input  logic [REG_AW-1:0] ID_EX_WriteReg,
    input  logic              EX_MEM_MemtoReg,
    input  logic              EX_MEM_RegWrite,
    input  logic [REG_AW-1:0] EX_MEM_WriteReg,
    input  logic              EqualFlag,
    output logic              PC_Stall,
    output logic              IF_ID_Stall,
    output logic              IF_ID_Flush,
    output logic              Control_Mux,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]  Stall_Count,
    output logic [CNT_W-1:0]  Flush_Count,
`endif
    output logic              MDU_Busy
);

    // A zero-latency MDU still needs a 1-bit counter so the register has a legal width.
    localparam int CW = (MDU_LAT > 0) ? $clog2(MDU_LAT + 1) : 1;

    typedef enum logic {IDLE, BUSY} mdu_state_t;

    mdu_state_t state, state_next;
    logic [CW-1:0] mdu_cnt, mdu_cnt_next;

    logic is_rtype, is_jr, is_jump, is_beq, is_bne, is_branch;
    logic is_muldiv, is_hilo;
    logic hit_ex, hit_mem;
    logic stall_load, stall_branch, stall_mdu, stall, flush, issue;

    always_comb begin
        is_rtype  = (IF_ID_OP == 6'h00);
        is_jr     = is_rtype && (IF_ID_Funct == 6'h08);
        is_jump   = (IF_ID_OP == 6'h02) || (IF_ID_OP == 6'h03);
        is_beq    = (IF_ID_OP == 6'h04);
        is_bne    = (IF_ID_OP == 6'h05);
        is_branch = is_beq || is_bne || is_jr;
        is_muldiv = is_rtype && (IF_ID_Funct >= 6'h18) && (IF_ID_Funct <= 6'h1B);
        is_hilo   = is_rtype && (IF_ID_Funct >= 6'h10) && (IF_ID_Funct <= 6'h13);
    end

    // Register 0 is hard-wired zero, so a dependency on it is never real.
    always_comb begin
        hit_ex  = (ID_EX_WriteReg != '0) &&
                  ((ID_EX_WriteReg == IF_ID_RS) ||
                   ((ID_EX_WriteReg == IF_ID_RT) && !IF_ID_invalidRt));
        hit_mem = (EX_MEM_WriteReg != '0) &&
                  ((EX_MEM_WriteReg == IF_ID_RS) ||
                   ((EX_MEM_WriteReg == IF_ID_RT) && !IF_ID_invalidRt));
    end

    always_comb begin
        MDU_Busy     = (state == BUSY);
        stall_load   = ID_EX_MemtoReg && hit_ex;
        stall_branch = is_branch && ((ID_EX_RegWrite && hit_ex) ||
                                     (EX_MEM_RegWrite && EX_MEM_MemtoReg && hit_mem));
        stall_mdu    = MDU_Busy && (is_muldiv || is_hilo);
        stall        = stall_load || stall_branch || stall_mdu;
        flush        = !stall && (is_jump || is_jr || (is_beq && EqualFlag) || (is_bne && !EqualFlag));
        issue        = is_muldiv && !stall;
    end

    always_comb begin
        PC_Stall    = stall;
        IF_ID_Stall = stall;
        Control_Mux = stall;
        IF_ID_Flush = flush;
    end

    // Scoreboard: BUSY exactly while the occupancy counter is non-zero.
    always_comb begin
        state_next   = state;
        mdu_cnt_next = mdu_cnt;
        if (issue) begin
            mdu_cnt_next = CW'(MDU_LAT);
            state_next   = (MDU_LAT != 0) ? BUSY : IDLE;
        end else if (mdu_cnt != '0) begin
            mdu_cnt_next = mdu_cnt - CW'(1);
            state_next   = (mdu_cnt == CW'(1)) ? IDLE : BUSY;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            mdu_cnt <= '0;
        end else begin
            state   <= state_next;
            mdu_cnt <= mdu_cnt_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating counters so a long stall never wraps back to a small value.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            if (stall && (Stall_Count != '1)) Stall_Count <= Stall_Count + CNT_W'(1);
            if (flush && (Flush_Count != '1)) Flush_Count <= Flush_Count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_mdu.sv
// Scoreboard bench for hazard_ctrl_mdu: directed scenarios plus random traffic against a reference model.
// Counter checks are active when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl_mdu;

    localparam int REG_AW  = 5;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [5:0]        op;
        logic [5:0]        funct;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              inv_rt;
        logic              ex_load;
        logic              ex_rw;
        logic [REG_AW-1:0] ex_wr;
        logic              mem_load;
        logic              mem_rw;
        logic [REG_AW-1:0] mem_wr;
        logic              eq;
        logic              rst_n;
    } stim_t;

    typedef struct {
        logic stall;
        logic flush;
        logic busy;
        int   stall_cnt;
        int   flush_cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [5:0]        op, funct;
    logic [REG_AW-1:0] rs, rt, ex_wr, mem_wr;
    logic              inv_rt, ex_load, ex_rw, mem_load, mem_rw, eq;
    logic              pc_stall, ifid_stall, ifid_flush, control_mux, mdu_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_count, flush_count;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   busy_until = 0;
    int   m_stall_cnt = 0;
    int   m_flush_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_ctrl_mdu #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .CLK(clk), .RST_N(rst_n),
        .IF_ID_OP(op), .IF_ID_Funct(funct), .IF_ID_RS(rs), .IF_ID_RT(rt),
        .IF_ID_invalidRt(inv_rt),
        .ID_EX_MemtoReg(ex_load), .ID_EX_RegWrite(ex_rw), .ID_EX_WriteReg(ex_wr),
        .EX_MEM_MemtoReg(mem_load), .EX_MEM_RegWrite(mem_rw), .EX_MEM_WriteReg(mem_wr),
        .EqualFlag(eq),
        .PC_Stall(pc_stall), .IF_ID_Stall(ifid_stall), .IF_ID_Flush(ifid_flush),
        .Control_Mux(control_mux),
`ifdef HAZARD_PERF_CNT_EN
        .Stall_Count(stall_count), .Flush_Count(flush_count),
`endif
        .MDU_Busy(mdu_busy)
    );

    function automatic stim_t idle();
        stim_t s;
        s = '{op: 6'h00, funct: 6'h20, rs: '0, rt: '0, inv_rt: 1'b0, ex_load: 1'b0, ex_rw: 1'b0,
              ex_wr: '0, mem_load: 1'b0, mem_rw: 1'b0, mem_wr: '0, eq: 1'b0, rst_n: 1'b1};
        return s;
    endfunction

    function automatic bit reads(stim_t s, logic [REG_AW-1:0] d);
        return (d != 0) && (d == s.rs || (d == s.rt && !s.inv_rt));
    endfunction

    // Reference model: the MDU is "busy" for the MDU_LAT cycles following an issue cycle.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   r_type, muldiv, hilo, jr, busy;
        @(posedge clk);
        #1;
        cyc++;
        {op, funct, rs, rt, inv_rt} = {s.op, s.funct, s.rs, s.rt, s.inv_rt};
        {ex_load, ex_rw, ex_wr, mem_load, mem_rw, mem_wr, eq, rst_n} =
            {s.ex_load, s.ex_rw, s.ex_wr, s.mem_load, s.mem_rw, s.mem_wr, s.eq, s.rst_n};
        r_type = (s.op == 0);
        muldiv = r_type && s.funct inside {[6'h18:6'h1B]};
        hilo   = r_type && s.funct inside {[6'h10:6'h13]};
        jr     = r_type && s.funct == 6'h08;
        busy   = cyc < busy_until;
        e.busy = busy;
        e.stall = (s.ex_load && reads(s, s.ex_wr)) ||
                  ((s.op == 4 || s.op == 5 || jr) &&
                   ((s.ex_rw && reads(s, s.ex_wr)) || (s.mem_rw && s.mem_load && reads(s, s.mem_wr)))) ||
                  (busy && (muldiv || hilo));
        e.flush = !e.stall && (s.op == 2 || s.op == 3 || jr || (s.op == 4 && s.eq) || (s.op == 5 && !s.eq));
        e.stall_cnt = m_stall_cnt;
        e.flush_cnt = m_flush_cnt;
        exp_q.push_back(e);
        if (!s.rst_n) begin
            busy_until  = 0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (muldiv && !e.stall) busy_until = cyc + MDU_LAT + 1;
            if (e.stall) m_stall_cnt = (m_stall_cnt < CNT_MAX) ? m_stall_cnt + 1 : CNT_MAX;
            if (e.flush) m_flush_cnt = (m_flush_cnt < CNT_MAX) ? m_flush_cnt + 1 : CNT_MAX;
        end
    endtask

    task automatic check1(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check1("pc_stall", int'(pc_stall), int'(e.stall));
        check1("ifid_stall", int'(ifid_stall), int'(e.stall));
        check1("control_mux", int'(control_mux), int'(e.stall));
        check1("ifid_flush", int'(ifid_flush), int'(e.flush));
        check1("mdu_busy", int'(mdu_busy), int'(e.busy));
`ifdef HAZARD_PERF_CNT_EN
        check1("stall_count", int'(stall_count), e.stall_cnt);
        check1("flush_count", int'(flush_count), e.flush_cnt);
`endif
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        stim_t s;
        s = idle();
        s.funct = 6'h00;
        {op, funct, rs, rt, inv_rt, ex_load, ex_rw, ex_wr, mem_load, mem_rw, mem_wr, eq} = '0;
        rst_n = 1'b0;
        s.rst_n = 1'b0;
        repeat (2) applyStimulus(s);
        s.rst_n = 1'b1;
        applyStimulus(s);

        // load-use on $t0, then the add proceeds
        s = idle(); s.rs = 8; s.rt = 10; s.ex_load = 1; s.ex_rw = 1; s.ex_wr = 8;
        applyStimulus(s);
        s.ex_load = 0; s.ex_rw = 0; s.ex_wr = 0;
        applyStimulus(s);

        // a load targeting $zero is not a hazard
        s = idle(); s.ex_load = 1; s.ex_rw = 1;
        applyStimulus(s);

        // beq waits for $t1 from EX, then takes the branch
        s = idle(); s.op = 6'h04; s.rs = 8; s.rt = 9; s.eq = 1; s.ex_rw = 1; s.ex_wr = 9;
        applyStimulus(s);
        s.ex_rw = 0; s.ex_wr = 0;
        applyStimulus(s);

        // mult then mflo: stalls for MDU_LAT cycles, released on the next
        s = idle(); s.funct = 6'h18; s.rs = 4; s.rt = 5;
        applyStimulus(s);
        s = idle(); s.funct = 6'h12; s.inv_rt = 1;
        repeat (MDU_LAT + 1) applyStimulus(s);

        // reset while busy aborts the scoreboard
        s = idle(); s.funct = 6'h18; s.rs = 4; s.rt = 5;
        applyStimulus(s);
        s = idle(); s.funct = 6'h12; s.inv_rt = 1; s.rst_n = 0;
        applyStimulus(s);
        s.rst_n = 1;
        repeat (2) applyStimulus(s);

        // long load-use stall drives the stall counter into saturation
        s = idle(); s.rs = 8; s.ex_load = 1; s.ex_rw = 1; s.ex_wr = 8;
        repeat (20) applyStimulus(s);

        for (int i = 0; i < 2000; i++) begin
            s = idle();
            case ($urandom_range(0, 7))
                0, 1: s.op = 6'h00;
                2:    s.op = 6'h02;
                3:    s.op = 6'h03;
                4:    s.op = 6'h04;
                5:    s.op = 6'h05;
                6:    s.op = 6'h23;
                default: s.op = 6'h08;
            endcase
            case ($urandom_range(0, 6))
                0: s.funct = 6'h20;
                1: s.funct = 6'h08;
                2: s.funct = 6'h10;
                3: s.funct = 6'h12;
                4: s.funct = 6'h18;
                5: s.funct = 6'h1B;
                default: s.funct = 6'h11;
            endcase
            s.rs       = REG_AW'($urandom_range(0, 3));
            s.rt       = REG_AW'($urandom_range(0, 3));
            s.inv_rt   = 1'($urandom_range(0, 1));
            s.ex_load  = ($urandom_range(0, 3) == 0);
            s.ex_rw    = 1'($urandom_range(0, 1));
            s.ex_wr    = REG_AW'($urandom_range(0, 3));
            s.mem_load = 1'($urandom_range(0, 1));
            s.mem_rw   = 1'($urandom_range(0, 1));
            s.mem_wr   = REG_AW'($urandom_range(0, 3));
            s.eq       = 1'($urandom_range(0, 1));
            s.rst_n    = ($urandom_range(0, 39) != 0);
            applyStimulus(s);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
